// File: rtl/clk_div_monitor_pkg.sv
// Shared clock-ratio header: monitor FSM encodings and the default divider ratio and lock settings,
// kept in one place so the divider and the monitor always agree on the expected ratio.
package clk_div_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } mon_state_t;

  localparam int DEF_CNT_W  = 16;
  localparam int DEF_EXPECT = 16;
  localparam int DEF_TOL    = 1;
  localparam int DEF_LOCK_N = 4;

endpackage

// File: rtl/clk_div_monitor_if.sv
// Divided-clock input, error clear and the measurement results of clk_div_monitor.
interface clk_div_monitor_if #(
  parameter int CNT_W = 16
);

  logic             clk_in;
  logic             clr;
  logic             rise_strobe;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             err;

  modport master (
    output clk_in, clr,
    input  rise_strobe, period, period_valid, locked, err
  );

  modport slave (
    input  clk_in, clr,
    output rise_strobe, period, period_valid, locked, err
  );

endinterface

// File: rtl/clk_div_monitor_clk_sync.sv
// Two-flop synchronizer with asynchronous reset for any single-bit asynchronous input.
module clk_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_div_monitor.sv
// Measures clk_in periods in clk_hf cycles and reports lock / sticky error; strobe latency 3 cycles,
// or 4 with CLK_MON_GLITCH_FILTER_EN (single-cycle highs rejected). No backpressure.
module clk_div_monitor
  import clk_div_monitor_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int EXPECT = DEF_EXPECT,
  parameter int TOL    = DEF_TOL,
  parameter int LOCK_N = DEF_LOCK_N
) (
  input logic              clk_hf,
  input logic              reset,
  clk_div_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   EXPECT_X  = (CNT_W+1)'(EXPECT);
  localparam logic [CNT_W:0]   TOL_X     = (CNT_W+1)'(TOL);
  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_N - 1);

  logic             in_sync;
  logic             prev_q;
  logic             edge_det;

  mon_state_t       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [3:0]       good_q, good_nxt;
  logic [CNT_W-1:0] period_q, period_nxt;
  logic             valid_nxt;
  logic             err_ev;

  logic             strobe_q;
  logic             valid_q;
  logic             locked_q;
  logic             set_err_q;
  logic             err_q;

  clk_sync u_sync (
    .clk (clk_hf),
    .rst (reset),
    .d   (bus.clk_in),
    .q   (in_sync)
  );

`ifdef CLK_MON_GLITCH_FILTER_EN
  logic prev2_q;

  always_ff @(posedge clk_hf or posedge reset) begin
    if (reset) begin
      prev_q  <= 1'b0;
      prev2_q <= 1'b0;
    end else begin
      prev_q  <= in_sync;
      prev2_q <= prev_q;
    end
  end

  // High must persist a second cycle after a low before the edge counts.
  assign edge_det = in_sync & prev_q & ~prev2_q;
`else
  always_ff @(posedge clk_hf or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= in_sync;
    end
  end

  assign edge_det = in_sync & ~prev_q;
`endif

  // Both operands are below 2^CNT_W, so the extra bit of the difference is a valid sign.
  function automatic logic in_tol(input logic [CNT_W-1:0] p);
    logic [CNT_W:0] ext;
    logic [CNT_W:0] diff;
    logic [CNT_W:0] mag;
    ext  = {1'b0, p};
    diff = ext - EXPECT_X;
    mag  = diff[CNT_W] ? (EXPECT_X - ext) : diff;
    return (mag <= TOL_X);
  endfunction

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    good_nxt   = good_q;
    period_nxt = period_q;
    valid_nxt  = 1'b0;
    err_ev     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (edge_det) begin
          state_nxt = ST_MEASURE;
          cnt_nxt   = CNT_ONE;
          good_nxt  = '0;
        end
      end
      ST_MEASURE, ST_LOCKED: begin
        if (cnt_q == CNT_MAX) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          good_nxt  = '0;
          err_ev    = 1'b1;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
          if (edge_det) begin
            // cnt_q equals the cycle distance since the previous strobe.
            period_nxt = cnt_q;
            valid_nxt  = 1'b1;
            cnt_nxt    = CNT_ONE;
            if (in_tol(cnt_q)) begin
              if (state_q == ST_MEASURE) begin
                if (good_q == LOCK_LAST) begin
                  state_nxt = ST_LOCKED;
                end
                good_nxt = good_q + 4'd1;
              end
            end else begin
              state_nxt = ST_MEASURE;
              good_nxt  = '0;
              err_ev    = 1'b1;
            end
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
        good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_hf or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      good_q    <= '0;
      period_q  <= '0;
      strobe_q  <= 1'b0;
      valid_q   <= 1'b0;
      set_err_q <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      good_q    <= good_nxt;
      period_q  <= period_nxt;
      strobe_q  <= edge_det;
      valid_q   <= valid_nxt;
      set_err_q <= err_ev;
      // Status lags the state change by one cycle; a set event beats a clear.
      locked_q  <= (state_q == ST_LOCKED);
      err_q     <= set_err_q | (err_q & ~bus.clr);
    end
  end

  assign bus.rise_strobe  = strobe_q;
  assign bus.period       = period_q;
  assign bus.period_valid = valid_q;
  assign bus.locked       = locked_q;
  assign bus.err          = err_q;

endmodule
